// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state encoding and counter sizing for the two-master Wishbone arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_MAXOUT  = 7;
    localparam int DEF_WDOG_W  = cnt_w(DEF_TIMEOUT - 1);
    localparam int DEF_OUT_W   = cnt_w(DEF_MAXOUT);

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - outstanding-strobe counter and hung-transfer watchdog
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int MAXOUT  = DEF_MAXOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic at_max_o,
    output logic expire_o
);

    localparam int OUT_W  = cnt_w(MAXOUT);
    localparam int WDOG_W = cnt_w(TIMEOUT - 1);
    localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(MAXOUT);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    logic [OUT_W-1:0]  out_q, out_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              dec_ok;

    // A response with nothing outstanding is stray and must not underflow.
    assign dec_ok = dec_i && (out_q != '0);

    always_comb begin
        out_d  = out_q;
        wdog_d = wdog_q;
        if (!en_i) begin
            out_d  = '0;
            wdog_d = '0;
        end else begin
            if (inc_i && !dec_ok) begin
                out_d = out_q + 1'b1;
            end else if (dec_ok && !inc_i) begin
                out_d = out_q - 1'b1;
            end
            if (dec_i || (out_q == '0)) begin
                wdog_d = '0;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q  <= '0;
            wdog_q <= '0;
        end else begin
            out_q  <= out_d;
            wdog_q <= wdog_d;
        end
    end

    assign at_max_o = (out_q == OUT_MAX);
    assign expire_o = en_i && (out_q != '0) && (wdog_q == WDOG_LAST);

endmodule

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master round-robin arbiter onto one pipelined Wishbone slave
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int AW      = 2,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int MAXOUT  = DEF_MAXOUT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_stall_o,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_stall_o,
    output logic [DW-1:0]   m1_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    input  logic            s_stall_i,
    input  logic [DW-1:0]   s_dat_i,
    output logic            owner_o,
    output logic            busy_o,
    output logic            timeout_o
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       gnt1, granted, own_cyc, own_stb, live, slv_err, at_max, expire;

    assign gnt1    = (state_q == ST_GNT1);
    assign granted = (state_q == ST_GNT0) || gnt1;
    assign own_cyc = gnt1 ? m1_cyc_i : m0_cyc_i;
    assign own_stb = gnt1 ? m1_stb_i : m0_stb_i;
    assign live    = granted && own_cyc;
    assign slv_err = s_err_i | s_rty_i;

    assign s_cyc_o = live;
    assign s_stb_o = live && own_stb && !at_max;
    assign s_we_o  = gnt1 ? m1_we_i  : m0_we_i;
    assign s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
    assign s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;
    assign s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;

    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign owner_o   = owner_q;
    assign busy_o    = (state_q != ST_IDLE);

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .MAXOUT  (MAXOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (live),
        .inc_i    (s_stb_o && !s_stall_i),
        .dec_i    (live && (s_ack_i || slv_err)),
        .at_max_o (at_max),
        .expire_o (expire)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        m0_stall_o = m0_cyc_i & m0_stb_i;
        m1_stall_o = m1_cyc_i & m1_stb_i;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_err_o   = 1'b0;
        timeout_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // On a tie the master that did not own the bus last wins.
                if (m0_cyc_i && (!m1_cyc_i || owner_q)) begin
                    state_d = ST_GNT0;
                    owner_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = ST_GNT1;
                    owner_d = 1'b1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                end else if (expire) begin
                    state_d = ST_ABORT;
                end
                if (gnt1) begin
                    m0_stall_o = 1'b1;
                    m1_stall_o = s_stall_i | at_max;
                    m1_ack_o   = s_ack_i & own_cyc;
                    m1_err_o   = slv_err & own_cyc;
                end else begin
                    m1_stall_o = 1'b1;
                    m0_stall_o = s_stall_i | at_max;
                    m0_ack_o   = s_ack_i & own_cyc;
                    m0_err_o   = slv_err & own_cyc;
                end
            end
            ST_ABORT: begin
                state_d   = ST_IDLE;
                timeout_o = 1'b1;
                if (owner_q) begin
                    m1_err_o = 1'b1;
                end else begin
                    m0_err_o = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - randomized self-checking bench for wb_arbiter2 against a transaction-level model
module tb_wb_arbiter2;

    localparam int AW      = 2;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int MAXOUT  = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0]   m0_adr_i;
    logic [DW/8-1:0] m0_sel_i;
    logic [DW-1:0]   m0_dat_i;
    logic            m0_ack_o, m0_err_o, m0_stall_o;
    logic [DW-1:0]   m0_dat_o;
    logic            m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0]   m1_adr_i;
    logic [DW/8-1:0] m1_sel_i;
    logic [DW-1:0]   m1_dat_i;
    logic            m1_ack_o, m1_err_o, m1_stall_o;
    logic [DW-1:0]   m1_dat_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW/8-1:0] s_sel_o;
    logic [DW-1:0]   s_dat_o;
    logic            s_ack_i, s_err_i, s_rty_i, s_stall_i;
    logic [DW-1:0]   s_dat_i;
    logic            owner_o, busy_o, timeout_o;

    int checks   = 0;
    int failures = 0;

    // Model: who holds the bus (-1 none), abort pending, last owner, outstanding, silent cycles.
    int ref_holder, ref_last, ref_pend, ref_silent;
    bit ref_abort;

    always #5 clk_i = ~clk_i;

    wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .MAXOUT(MAXOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_stall_o(m0_stall_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_stall_o(m1_stall_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_stall_i(s_stall_i),
        .s_dat_i(s_dat_i),
        .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic ref_reset();
        ref_holder = -1;
        ref_last   = 1;
        ref_pend   = 0;
        ref_silent = 0;
        ref_abort  = 1'b0;
    endtask

    task automatic drive_idle();
        {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i} = '0;
        m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = '0;
        m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = '0;
        {s_ack_i, s_err_i, s_rty_i, s_stall_i} = '0;
        s_dat_i = '0;
    endtask

    // Inputs are already applied; check every output against the model, advance it, go to next negedge.
    task automatic step();
        logic [1:0] c, s, e_stall, e_ack, e_err;
        logic       e_scyc, e_sstb, e_to, e_busy, hc, resp, acc, full, expired;
        int         h, winner, old;
        c = {m1_cyc_i, m0_cyc_i};
        s = {m1_stb_i, m0_stb_i};
        e_stall = c & s; e_ack = '0; e_err = '0;
        e_scyc = 0; e_sstb = 0; e_to = 0; e_busy = 0; hc = 0; acc = 0;
        h = ref_holder;
        resp = s_ack_i | s_err_i | s_rty_i;
        if (ref_abort) begin
            e_busy = 1; e_to = 1; e_err[ref_last] = 1'b1;
        end else if (h >= 0) begin
            hc = c[h];
            full = (ref_pend == MAXOUT);
            e_busy = 1; e_scyc = hc; e_sstb = hc & s[h] & !full;
            e_stall[h] = s_stall_i | full;
            e_stall[1-h] = 1'b1;
            e_ack[h] = s_ack_i & hc;
            e_err[h] = (s_err_i | s_rty_i) & hc;
            acc = e_sstb & !s_stall_i;
        end
        #1;
        check_eq("s_cyc", s_cyc_o, e_scyc);
        check_eq("s_stb", s_stb_o, e_sstb);
        check_eq("stall", {m1_stall_o, m0_stall_o}, e_stall);
        check_eq("ack", {m1_ack_o, m0_ack_o}, e_ack);
        check_eq("err", {m1_err_o, m0_err_o}, e_err);
        check_eq("timeout", timeout_o, e_to);
        check_eq("busy", busy_o, e_busy);
        check_eq("owner", owner_o, ref_last);
        check_eq("m0_dat", m0_dat_o, s_dat_i);
        check_eq("m1_dat", m1_dat_o, s_dat_i);
        if (e_scyc) begin
            check_eq("s_we", s_we_o, (h == 1) ? m1_we_i : m0_we_i);
            check_eq("s_adr", s_adr_o, (h == 1) ? m1_adr_i : m0_adr_i);
            check_eq("s_sel", s_sel_o, (h == 1) ? m1_sel_i : m0_sel_i);
            check_eq("s_dat", s_dat_o, (h == 1) ? m1_dat_i : m0_dat_i);
        end
        if (rst_i) begin
            ref_reset();
        end else if (ref_abort) begin
            ref_abort = 1'b0;
            ref_holder = -1;
        end else if (h < 0) begin
            if (c == 2'b11) winner = 1 - ref_last;
            else if (c[0]) winner = 0;
            else if (c[1]) winner = 1;
            else winner = -1;
            if (winner >= 0) begin
                ref_holder = winner;
                ref_last = winner;
            end
        end else if (!hc) begin
            ref_holder = -1; ref_pend = 0; ref_silent = 0;
        end else begin
            old = ref_pend;
            expired = (old > 0) && (ref_silent == TIMEOUT - 1);
            ref_pend = (resp && old > 0) ? old - 1 + int'(acc) : old + int'(acc);
            ref_silent = (resp || old == 0) ? 0 : ref_silent + 1;
            if (expired) begin
                ref_abort = 1'b1; ref_holder = -1; ref_pend = 0; ref_silent = 0;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic rand_master(inout logic cyc, output logic stb, output logic we,
                               output logic [AW-1:0] adr, output logic [DW/8-1:0] sel,
                               output logic [DW-1:0] dat);
        if (!cyc) cyc = ($urandom_range(0, 5) == 0);
        else if ($urandom_range(0, 11) == 0) cyc = 1'b0;
        stb = cyc & ($urandom_range(0, 9) < 7);
        we  = 1'($urandom_range(0, 1));
        adr = AW'($urandom);
        sel = (DW/8)'($urandom);
        dat = $urandom;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        int found, hang, r;
        drive_idle();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        ref_reset();
        rst_i = 1'b0;
        #1;
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_owner", owner_o, 1);
        check_eq("rst_scyc", s_cyc_o, 0);
        check_eq("rst_timeout", timeout_o, 0);
        step();

        // Lone m0 write.
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 2'd1; m0_sel_i = 4'hf; m0_dat_i = 32'h1234_5678;
        #1;
        check_eq("t1_idle_stall", m0_stall_o, 1);
        check_eq("t1_idle_scyc", s_cyc_o, 0);
        step();
        #1;
        check_eq("t1_scyc", s_cyc_o, 1);
        check_eq("t1_sdat", s_dat_o, 32'h1234_5678);
        check_eq("t1_owner", owner_o, 0);
        step();
        m0_stb_i = 0; s_ack_i = 1;
        #1;
        check_eq("t1_m0_ack", m0_ack_o, 1);
        check_eq("t1_m1_ack", m1_ack_o, 0);
        step();
        s_ack_i = 0; m0_cyc_i = 0;
        step();
        step();

        // Tie from reset, alternation, and m1 locked out while m0 holds the bus.
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        #1;
        check_eq("t2_owner_m0", owner_o, 0);
        check_eq("t3_m1_stall", m1_stall_o, 1);
        check_eq("t3_no_stb", s_stb_o, 0);
        step();
        m0_stb_i = 1;
        step();
        m0_cyc_i = 0; m0_stb_i = 0;
        step();
        #1;
        check_eq("t2_dead_cycle", busy_o, 0);
        step();
        #1;
        check_eq("t2_owner_m1", owner_o, 1);
        check_eq("t2_m1_scyc", s_cyc_o, 1);
        step();
        m1_cyc_i = 0; m1_stb_i = 0;
        step();
        m0_cyc_i = 1; m1_cyc_i = 1;
        step();
        #1;
        check_eq("t2_alternate", owner_o, 0);
        step();
        drive_idle();
        step();
        step();

        // Slave never answers: watchdog abort.
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        step();
        m0_stb_i = 0;
        found = -1;
        for (int k = 1; k <= 40 && found < 0; k++) begin
            #1;
            if (timeout_o === 1'b1) begin
                found = k;
                check_eq("t4_err", m0_err_o, 1);
                check_eq("t4_scyc", s_cyc_o, 0);
            end
            step();
        end
        check_eq("t4_latency", found, TIMEOUT + 1);
        #1;
        check_eq("t4_idle_after", busy_o, 0);
        check_eq("t4_pulse", timeout_o, 0);
        m0_cyc_i = 0;
        step();

        // Retry and error on a read both surface as err.
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
        step();
        step();
        m0_stb_i = 0; s_rty_i = 1;
        #1;
        check_eq("t5_rty_err", m0_err_o, 1);
        check_eq("t5_rty_ack", m0_ack_o, 0);
        step();
        s_rty_i = 0; s_err_i = 1;
        #1;
        check_eq("t5_err", m0_err_o, 1);
        step();
        drive_idle();
        step();

        // Fill to MAXOUT, then reset with responses in flight.
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        step();
        step();
        #1;
        check_eq("t6_full_stall", m0_stall_o, 1);
        check_eq("t6_full_stb", s_stb_o, 0);
        step();
        rst_i = 1; s_ack_i = 1;
        step();
        rst_i = 0;
        #1;
        check_eq("t6_rst_scyc", s_cyc_o, 0);
        check_eq("t6_rst_owner", owner_o, 1);
        check_eq("t6_late_ack", m0_ack_o, 0);
        step();
        drive_idle();
        step();
        step();

        // Randomized traffic.
        hang = 0;
        for (int n = 0; n < 3000; n++) begin
            rst_i = ($urandom_range(0, 399) == 0);
            rand_master(m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i);
            rand_master(m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i);
            s_stall_i = ($urandom_range(0, 3) == 0);
            s_dat_i = $urandom;
            s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
            if (hang > 0) begin
                hang--;
            end else if ($urandom_range(0, 99) == 0) begin
                hang = 25;
            end else if ((ref_pend > 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 49) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 8) s_ack_i = 1;
                else if (r == 8) s_err_i = 1;
                else s_rty_i = 1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
